// File: rtl/multicycle_main_fsm_if.sv
// Memory handshake bundle between the multicycle control FSM and shared memory.
//   mem_req   : access request (FSM -> memory)
//   mem_write : write strobe, valid with mem_req (FSM -> memory)
//   adr_src   : address select, 0 = PC, 1 = ALUOut (FSM -> datapath mux)
//   mem_ready : memory completes the current access this cycle (memory -> FSM)
interface multicycle_main_fsm_if;
    logic mem_req;
    logic mem_write;
    logic adr_src;
    logic mem_ready;

    modport master (
        output mem_req,
        output mem_write,
        output adr_src,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_write,
        input  adr_src,
        output mem_ready
    );
endinterface

// File: rtl/multicycle_main_fsm.sv
// Control FSM for the multicycle RV32I datapath (lw, sw, R, I-ALU, beq, jal, lui).
// Sequences FETCH/DECODE/EXECUTE/WRITEBACK over shared memory with a ready
// handshake and a wait timeout; counts retired instructions, flags illegal
// opcodes and sticky memory-timeout faults.
// Optional: define MAIN_FSM_JALR_EN to add jalr (DECODE -> JALR -> JAL -> ALUWB).
// Ports:
//   clk, rst_n      : clock, synchronous active-low reset
//   mem             : memory handshake (mem_req, mem_write, adr_src, mem_ready)
//   opc, zero       : instruction opcode, ALU zero flag
//   ir_write, pc_write, reg_write : datapath strobes
//   result_src, alu_src_a, alu_src_b, alu_op, imm_src : datapath selects
//   illegal, fault  : unsupported-opcode pulse, sticky timeout fault
//   retired, state_o: retired-instruction count, current state for debug
module multicycle_main_fsm #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    multicycle_main_fsm_if.master mem,
    input  logic [6:0]            opc,
    input  logic                  zero,
    output logic                  ir_write,
    output logic                  pc_write,
    output logic                  reg_write,
    output logic [1:0]            result_src,
    output logic [1:0]            alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic [1:0]            alu_op,
    output logic [2:0]            imm_src,
    output logic                  illegal,
    output logic                  fault,
    output logic [CNT_W-1:0]      retired,
    output logic [3:0]            state_o
);

    localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST =
        TO_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
    localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

    localparam logic [3:0] S_FETCH   = 4'd0;
    localparam logic [3:0] S_DECODE  = 4'd1;
    localparam logic [3:0] S_MEMADR  = 4'd2;
    localparam logic [3:0] S_MEMRD   = 4'd3;
    localparam logic [3:0] S_MEMWB   = 4'd4;
    localparam logic [3:0] S_MEMWR   = 4'd5;
    localparam logic [3:0] S_EXECR   = 4'd6;
    localparam logic [3:0] S_EXECI   = 4'd7;
    localparam logic [3:0] S_ALUWB   = 4'd8;
    localparam logic [3:0] S_BEQ     = 4'd9;
    localparam logic [3:0] S_JAL     = 4'd10;
    localparam logic [3:0] S_LUI     = 4'd11;
    localparam logic [3:0] S_ILLEGAL = 4'd12;
    localparam logic [3:0] S_FAULT   = 4'd13;
`ifdef MAIN_FSM_JALR_EN
    localparam logic [3:0] S_JALR    = 4'd14;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
`endif

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_LUI = 7'b0110111;

    logic [3:0]       state_q, state_d;
    logic [TO_W-1:0]  to_cnt_q;
    logic [CNT_W-1:0] retired_q;
    logic             fault_q;

    logic mreq, mwr, irw, pc_upd, branch, rw, retire, wait_hit;

    // Last permitted wait cycle with no ready: abandon the access
    assign wait_hit = TO_EN && (to_cnt_q == TO_LAST) && !mem.mem_ready;

    // Next state and per-state outputs
    always_comb begin
        state_d     = state_q;
        mreq        = 1'b0;
        mwr         = 1'b0;
        irw         = 1'b0;
        pc_upd      = 1'b0;
        branch      = 1'b0;
        rw          = 1'b0;
        retire      = 1'b0;
        illegal     = 1'b0;
        mem.adr_src = 1'b0;
        result_src  = 2'b00;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        alu_op      = 2'b00;
        case (state_q)
            S_FETCH: begin
                mreq       = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                irw        = mem.mem_ready;
                pc_upd     = mem.mem_ready;
                if (mem.mem_ready)  state_d = S_DECODE;
                else if (wait_hit)  state_d = S_FAULT;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (opc)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    OP_LUI:       state_d = S_LUI;
`ifdef MAIN_FSM_JALR_EN
                    OP_JALR:      state_d = S_JALR;
`endif
                    default:      state_d = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_d   = (opc == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                mreq        = 1'b1;
                mem.adr_src = 1'b1;
                if (mem.mem_ready)  state_d = S_MEMWB;
                else if (wait_hit)  state_d = S_FAULT;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                rw         = 1'b1;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                mreq        = 1'b1;
                mwr         = 1'b1;
                mem.adr_src = 1'b1;
                if (mem.mem_ready) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else if (wait_hit) begin
                    state_d = S_FAULT;
                end
            end
            S_EXECR: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
                state_d   = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                rw      = 1'b1;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_BEQ: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                branch    = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_JAL: begin
                // PC takes the target held in ALUOut while the ALU forms OldPC+4
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_upd    = 1'b1;
                state_d   = S_ALUWB;
            end
            S_LUI: begin
                result_src = 2'b11;
                rw         = 1'b1;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_ILLEGAL: begin
                illegal = 1'b1;
                state_d = S_FETCH;
            end
`ifdef MAIN_FSM_JALR_EN
            S_JALR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_d   = S_JAL;
            end
`endif
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_FETCH;
        endcase
    end

    // Immediate format straight from the opcode
    always_comb begin
        case (opc)
            OP_SW:   imm_src = 3'b001;
            OP_BEQ:  imm_src = 3'b010;
            OP_JAL:  imm_src = 3'b011;
            OP_LUI:  imm_src = 3'b100;
            default: imm_src = 3'b000;
        endcase
    end

    // State, timeout counter, retire counter and sticky fault
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            to_cnt_q  <= '0;
            retired_q <= '0;
            fault_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (retire)
                retired_q <= retired_q + CNT_W'(1);
            if ((state_d != state_q) || mem.mem_ready || !mreq)
                to_cnt_q <= '0;
            else
                to_cnt_q <= to_cnt_q + TO_W'(1);
            if (state_d == S_FAULT)
                fault_q <= 1'b1;
        end
    end

    // Strobes are suppressed during the reset cycle so an abandoned access never writes
    assign mem.mem_req   = rst_n & mreq;
    assign mem.mem_write = rst_n & mwr;
    assign ir_write      = rst_n & irw;
    assign pc_write      = rst_n & (pc_upd | (branch & zero));
    assign reg_write     = rst_n & rw;

    assign fault   = fault_q;
    assign retired = retired_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Self-checking bench for multicycle_main_fsm (TIMEOUT_CYCLES = 4).
// Directed instruction sequence; per-cycle expectations are queued as inputs
// are driven and popped/compared once the outputs settle.
module tb_multicycle_main_fsm;

    localparam logic [3:0] S_FETCH   = 4'd0;
    localparam logic [3:0] S_DECODE  = 4'd1;
    localparam logic [3:0] S_MEMADR  = 4'd2;
    localparam logic [3:0] S_MEMRD   = 4'd3;
    localparam logic [3:0] S_MEMWB   = 4'd4;
    localparam logic [3:0] S_MEMWR   = 4'd5;
    localparam logic [3:0] S_EXECR   = 4'd6;
    localparam logic [3:0] S_EXECI   = 4'd7;
    localparam logic [3:0] S_ALUWB   = 4'd8;
    localparam logic [3:0] S_BEQ     = 4'd9;
    localparam logic [3:0] S_JAL     = 4'd10;
    localparam logic [3:0] S_LUI     = 4'd11;
    localparam logic [3:0] S_ILLEGAL = 4'd12;
    localparam logic [3:0] S_FAULT   = 4'd13;
    localparam logic [3:0] S_JALR    = 4'd14;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_SYS  = 7'b1110011;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    typedef struct packed {
        logic [3:0]  st;
        logic [4:0]  strb;   // mem_req, mem_write, ir_write, pc_write, reg_write
        logic [8:0]  sel;    // adr_src, result_src, alu_src_a, alu_src_b, alu_op
        logic [2:0]  imm;
        logic        ill;
        logic        flt;
        logic [31:0] ret;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  opc;
    logic        zero;
    logic        ir_write, pc_write, reg_write, illegal, fault;
    logic [1:0]  result_src, alu_src_a, alu_src_b, alu_op;
    logic [2:0]  imm_src;
    logic [31:0] retired;
    logic [3:0]  state_o;

    exp_t        sb[$];
    int          pass_cnt = 0;
    int          fail_cnt = 0;
    int          total    = 0;
    logic [31:0] r        = 32'd0;

    multicycle_main_fsm_if bus();

    multicycle_main_fsm #(.TIMEOUT_CYCLES(4), .CNT_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem        (bus),
        .opc        (opc),
        .zero       (zero),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .reg_write  (reg_write),
        .result_src (result_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .imm_src    (imm_src),
        .illegal    (illegal),
        .fault      (fault),
        .retired    (retired),
        .state_o    (state_o)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] imm_of(input logic [6:0] o);
        case (o)
            OP_SW:   return 3'b001;
            OP_BEQ:  return 3'b010;
            OP_JAL:  return 3'b011;
            OP_LUI:  return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    // Output table for one cycle, written from the state descriptions
    function automatic exp_t model(input logic [3:0] st, input logic rdy, input logic z,
                                   input logic rn, input logic [6:0] o, input logic [31:0] ret);
        exp_t e;
        logic mreq, mwr, irw, pcw, rw, adr;
        logic [1:0] rs, a, b, op;
        {mreq, mwr, irw, pcw, rw, adr} = 6'b0;
        {rs, a, b, op} = 8'b0;
        case (st)
            S_FETCH:  begin mreq = 1'b1; b = 2'b10; rs = 2'b10; irw = rdy; pcw = rdy; end
            S_DECODE: begin a = 2'b01; b = 2'b01; end
            S_MEMADR: begin a = 2'b10; b = 2'b01; end
            S_MEMRD:  begin mreq = 1'b1; adr = 1'b1; end
            S_MEMWB:  begin rs = 2'b01; rw = 1'b1; end
            S_MEMWR:  begin mreq = 1'b1; mwr = 1'b1; adr = 1'b1; end
            S_EXECR:  begin a = 2'b10; op = 2'b10; end
            S_EXECI:  begin a = 2'b10; b = 2'b01; op = 2'b10; end
            S_ALUWB:  rw = 1'b1;
            S_BEQ:    begin a = 2'b10; op = 2'b01; pcw = z; end
            S_JAL:    begin a = 2'b01; b = 2'b10; pcw = 1'b1; end
            S_LUI:    begin rs = 2'b11; rw = 1'b1; end
            S_JALR:   begin a = 2'b10; b = 2'b01; end
            default:  ;
        endcase
        if (!rn) {mreq, mwr, irw, pcw, rw} = 5'b0;
        e.st   = st;
        e.strb = {mreq, mwr, irw, pcw, rw};
        e.sel  = {adr, rs, a, b, op};
        e.imm  = imm_of(o);
        e.ill  = (st == S_ILLEGAL);
        e.flt  = (st == S_FAULT);
        e.ret  = ret;
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, queue the expectation, then compare settled outputs
    task automatic cyc(input logic [6:0] o, input logic z, input logic rdy, input logic rn,
                       input logic [3:0] est, input string tag);
        exp_t e;
        @(negedge clk);
        opc = o; zero = z; bus.mem_ready = rdy; rst_n = rn;
        sb.push_back(model(est, rdy, z, rn, o, r));
        #1;
        e = sb.pop_front();
        check({tag, ".state"},   32'(state_o), 32'(e.st));
        check({tag, ".strobes"}, 32'({bus.mem_req, bus.mem_write, ir_write, pc_write, reg_write}), 32'(e.strb));
        check({tag, ".selects"}, 32'({bus.adr_src, result_src, alu_src_a, alu_src_b, alu_op}), 32'(e.sel));
        check({tag, ".imm_src"}, 32'(imm_src), 32'(e.imm));
        check({tag, ".illegal"}, 32'(illegal), 32'(e.ill));
        check({tag, ".fault"},   32'(fault), 32'(e.flt));
        check({tag, ".retired"}, retired, e.ret);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; opc = 7'd0; zero = 1'b0; bus.mem_ready = 1'b0;
        @(negedge clk);
        cyc(OP_R, 0, 1, 0, S_FETCH, "reset");

        // R-type
        cyc(OP_R, 0, 1, 1, S_FETCH,  "r.fetch");
        cyc(OP_R, 0, 1, 1, S_DECODE, "r.decode");
        cyc(OP_R, 0, 1, 1, S_EXECR,  "r.exec");
        cyc(OP_R, 0, 1, 1, S_ALUWB,  "r.wb");
        r = 32'd1;

        // lw with three wait cycles; ready arrives as the counter hits its last value
        cyc(OP_LW, 0, 1, 1, S_FETCH,  "lw.fetch");
        cyc(OP_LW, 0, 1, 1, S_DECODE, "lw.decode");
        cyc(OP_LW, 0, 1, 1, S_MEMADR, "lw.memadr");
        for (int i = 0; i < 3; i++) cyc(OP_LW, 0, 0, 1, S_MEMRD, "lw.memrd_wait");
        cyc(OP_LW, 0, 1, 1, S_MEMRD,  "lw.memrd_done");
        cyc(OP_LW, 0, 1, 1, S_MEMWB,  "lw.memwb");
        r = 32'd2;

        // sw with a short fetch stall
        cyc(OP_SW, 0, 0, 1, S_FETCH,  "sw.fetch_wait");
        cyc(OP_SW, 0, 0, 1, S_FETCH,  "sw.fetch_wait");
        cyc(OP_SW, 0, 1, 1, S_FETCH,  "sw.fetch");
        cyc(OP_SW, 0, 1, 1, S_DECODE, "sw.decode");
        cyc(OP_SW, 0, 1, 1, S_MEMADR, "sw.memadr");
        cyc(OP_SW, 0, 1, 1, S_MEMWR,  "sw.memwr");
        r = 32'd3;

        // beq taken then not taken
        cyc(OP_BEQ, 1, 1, 1, S_FETCH,  "beq1.fetch");
        cyc(OP_BEQ, 1, 1, 1, S_DECODE, "beq1.decode");
        cyc(OP_BEQ, 1, 1, 1, S_BEQ,    "beq1.taken");
        r = 32'd4;
        cyc(OP_BEQ, 0, 1, 1, S_FETCH,  "beq0.fetch");
        cyc(OP_BEQ, 0, 1, 1, S_DECODE, "beq0.decode");
        cyc(OP_BEQ, 0, 1, 1, S_BEQ,    "beq0.not_taken");
        r = 32'd5;

        // lui
        cyc(OP_LUI, 0, 1, 1, S_FETCH,  "lui.fetch");
        cyc(OP_LUI, 0, 1, 1, S_DECODE, "lui.decode");
        cyc(OP_LUI, 0, 1, 1, S_LUI,    "lui.wb");
        r = 32'd6;

        // jal
        cyc(OP_JAL, 0, 1, 1, S_FETCH,  "jal.fetch");
        cyc(OP_JAL, 0, 1, 1, S_DECODE, "jal.decode");
        cyc(OP_JAL, 0, 1, 1, S_JAL,    "jal.jal");
        cyc(OP_JAL, 0, 1, 1, S_ALUWB,  "jal.wb");
        r = 32'd7;

        // I-type ALU
        cyc(OP_I, 0, 1, 1, S_FETCH,  "i.fetch");
        cyc(OP_I, 0, 1, 1, S_DECODE, "i.decode");
        cyc(OP_I, 0, 1, 1, S_EXECI,  "i.exec");
        cyc(OP_I, 0, 1, 1, S_ALUWB,  "i.wb");
        r = 32'd8;

        // unsupported opcode: one-cycle illegal, no retire
        cyc(OP_SYS, 0, 1, 1, S_FETCH,   "ill.fetch");
        cyc(OP_SYS, 0, 1, 1, S_DECODE,  "ill.decode");
        cyc(OP_SYS, 0, 1, 1, S_ILLEGAL, "ill.pulse");

        // jalr
        cyc(OP_JALR, 0, 1, 1, S_FETCH,  "jalr.fetch");
        cyc(OP_JALR, 0, 1, 1, S_DECODE, "jalr.decode");
`ifdef MAIN_FSM_JALR_EN
        cyc(OP_JALR, 0, 1, 1, S_JALR,  "jalr.jalr");
        cyc(OP_JALR, 0, 1, 1, S_JAL,   "jalr.jal");
        cyc(OP_JALR, 0, 1, 1, S_ALUWB, "jalr.wb");
        r = 32'd9;
`else
        cyc(OP_JALR, 0, 1, 1, S_ILLEGAL, "jalr.illegal");
`endif

        // reset in the middle of a stalled store
        cyc(OP_SW, 0, 1, 1, S_FETCH,  "swrst.fetch");
        cyc(OP_SW, 0, 1, 1, S_DECODE, "swrst.decode");
        cyc(OP_SW, 0, 1, 1, S_MEMADR, "swrst.memadr");
        cyc(OP_SW, 0, 0, 1, S_MEMWR,  "swrst.memwr_wait");
        cyc(OP_SW, 0, 0, 0, S_MEMWR,  "swrst.reset_cycle");
        r = 32'd0;

        // fetch timeout: fault after four waiting cycles, held until reset
        for (int i = 0; i < 4; i++) cyc(OP_R, 0, 0, 1, S_FETCH, "to.fetch_wait");
        cyc(OP_R, 0, 0, 1, S_FAULT, "to.fault");
        cyc(OP_R, 0, 1, 1, S_FAULT, "to.fault_ready");
        cyc(OP_R, 1, 0, 1, S_FAULT, "to.fault_hold");
        cyc(OP_R, 0, 1, 0, S_FAULT, "to.reset_cycle");
        cyc(OP_R, 0, 1, 1, S_FETCH, "to.recovered");
        cyc(OP_R, 0, 1, 1, S_DECODE, "to.decode");

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
